// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - sector scan frame controller that sequences scanlines into the Transmitter
module scan_sequencer #(
  parameter int DW_ANGLE  = 8,
  parameter int DW_INPUT  = 8,
  parameter int DW_POINTS = 13,
  parameter int DW_DWELL  = 16,
  parameter int TIMEOUT   = 4095
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [DW_ANGLE-1:0]  angle_start_i,
  input  logic [DW_ANGLE-1:0]  angle_stop_i,
  input  logic [DW_ANGLE-1:0]  angle_step_i,
  input  logic [DW_INPUT-1:0]  r_0_cfg_i,
  input  logic [DW_POINTS-1:0] num_points_cfg_i,
  input  logic [DW_DWELL-1:0]  dwell_cycles_i,
  input  logic                 tx_done_i,
  output logic [DW_INPUT-1:0]  r_0_o,
  output logic [DW_ANGLE-1:0]  angle_o,
  output logic [DW_POINTS-1:0] num_points_o,
  output logic                 initiate_o,
  output logic                 busy_o,
  output logic [7:0]           line_idx_o,
  output logic                 frame_done_o,
  output logic                 error_o
);

  // Watchdog counter is wide enough to hold TIMEOUT; the last WAIT_TX
  // cycle is the one where the counter already holds TIMEOUT-1.
  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FIRE,
    S_WAIT_TX,
    S_DWELL,
    S_NEXT,
    S_FINISH
  } state_t;

  state_t               state_q, state_d;
  logic [DW_ANGLE-1:0]  angle_q, angle_d;
  logic [DW_ANGLE-1:0]  stop_q, stop_d;
  logic [DW_ANGLE-1:0]  step_q, step_d;
  logic [DW_INPUT-1:0]  r_0_q, r_0_d;
  logic [DW_POINTS-1:0] num_points_q, num_points_d;
  logic [DW_DWELL-1:0]  dwell_cfg_q, dwell_cfg_d;
  logic [DW_DWELL-1:0]  dwell_cnt_q, dwell_cnt_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [7:0]           line_idx_q, line_idx_d;
  logic                 error_q, error_d;

  // One extra bit so an angle that runs past the top of the range is
  // seen as beyond angle_stop instead of wrapping back into the sector.
  logic [DW_ANGLE:0]    nxt_angle;

  // State and datapath registers; everything returns to zero/IDLE on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      angle_q      <= '0;
      stop_q       <= '0;
      step_q       <= '0;
      r_0_q        <= '0;
      num_points_q <= '0;
      dwell_cfg_q  <= '0;
      dwell_cnt_q  <= '0;
      wd_q         <= '0;
      line_idx_q   <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      angle_q      <= angle_d;
      stop_q       <= stop_d;
      step_q       <= step_d;
      r_0_q        <= r_0_d;
      num_points_q <= num_points_d;
      dwell_cfg_q  <= dwell_cfg_d;
      dwell_cnt_q  <= dwell_cnt_d;
      wd_q         <= wd_d;
      line_idx_q   <= line_idx_d;
      error_q      <= error_d;
    end
  end

  // Next-state, datapath updates and the two strobes; abort overrides all.
  always_comb begin
    state_d      = state_q;
    angle_d      = angle_q;
    stop_d       = stop_q;
    step_d       = step_q;
    r_0_d        = r_0_q;
    num_points_d = num_points_q;
    dwell_cfg_d  = dwell_cfg_q;
    dwell_cnt_d  = dwell_cnt_q;
    wd_d         = wd_q;
    line_idx_d   = line_idx_q;
    error_d      = error_q;
    initiate_o   = 1'b0;
    frame_done_o = 1'b0;
    nxt_angle    = {1'b0, angle_q} + {1'b0, step_q};

    if (abort_i) begin
      // Registers hold; only the state is forced home. error is untouched.
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_d = S_LOAD;
            error_d = 1'b0;
          end
        end

        S_LOAD: begin
          // Snapshot the whole frame configuration; later input changes
          // have no effect until the next frame.
          angle_d      = angle_start_i;
          stop_d       = angle_stop_i;
          step_d       = angle_step_i;
          r_0_d        = r_0_cfg_i;
          num_points_d = num_points_cfg_i;
          dwell_cfg_d  = dwell_cycles_i;
          line_idx_d   = '0;
          state_d      = S_FIRE;
        end

        S_FIRE: begin
          initiate_o = 1'b1;
          wd_d       = '0;
          state_d    = S_WAIT_TX;
        end

        S_WAIT_TX: begin
          if (tx_done_i) begin
            dwell_cnt_d = dwell_cfg_q;
            state_d     = S_DWELL;
          end else if (wd_q == WD_LAST) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
        end

        S_DWELL: begin
          // A dwell of 0 or 1 both take a single cycle here.
          if (dwell_cnt_q <= DW_DWELL'(1)) begin
            state_d = S_NEXT;
          end else begin
            dwell_cnt_d = dwell_cnt_q - DW_DWELL'(1);
          end
        end

        S_NEXT: begin
          if ((step_q == '0) || (nxt_angle > {1'b0, stop_q})) begin
            state_d = S_FINISH;
          end else begin
            angle_d = nxt_angle[DW_ANGLE-1:0];
            if (line_idx_q != 8'hFF) begin
              line_idx_d = line_idx_q + 8'd1;
            end
            state_d = S_FIRE;
          end
        end

        S_FINISH: begin
          frame_done_o = 1'b1;
          state_d      = S_IDLE;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  assign angle_o      = angle_q;
  assign r_0_o        = r_0_q;
  assign num_points_o = num_points_q;
  assign line_idx_o   = line_idx_q;
  assign error_o      = error_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// tb/tb_scan_sequencer.sv - self-checking bench for scan_sequencer
module tb_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        start_i, abort_i, tx_done_i;
  logic [7:0]  angle_start_i, angle_stop_i, angle_step_i, r_0_cfg_i;
  logic [12:0] num_points_cfg_i;
  logic [15:0] dwell_cycles_i;
  logic [7:0]  r_0_o, angle_o, line_idx_o;
  logic [12:0] num_points_o;
  logic        initiate_o, busy_o, frame_done_o, error_o;

  always #5 clk = ~clk;

  scan_sequencer #(
    .DW_ANGLE(8), .DW_INPUT(8), .DW_POINTS(13), .DW_DWELL(16), .TIMEOUT(4095)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .angle_start_i(angle_start_i), .angle_stop_i(angle_stop_i),
    .angle_step_i(angle_step_i), .r_0_cfg_i(r_0_cfg_i),
    .num_points_cfg_i(num_points_cfg_i), .dwell_cycles_i(dwell_cycles_i),
    .tx_done_i(tx_done_i), .r_0_o(r_0_o), .angle_o(angle_o),
    .num_points_o(num_points_o), .initiate_o(initiate_o), .busy_o(busy_o),
    .line_idx_o(line_idx_o), .frame_done_o(frame_done_o), .error_o(error_o)
  );

  typedef struct {
    int a0, a1, st, d, lat, mode;
    int exp_lines, exp_last;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int resp_mode = 1;   // 0: pulse done resp_lat cycles after initiate, 1: never, 2: held high
  int resp_lat = 1;
  int cur_r0, cur_np;
  int ini_cyc[$], ini_ang[$], ini_idx[$], ini_r0[$], ini_np[$], fd_cyc[$];
  int exp_ang[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Log every initiate / frame_done pulse with its cycle number.
  always @(negedge clk) begin
    if (rst_ni) begin
      if (initiate_o) begin
        ini_cyc.push_back(cyc);
        ini_ang.push_back(int'(angle_o));
        ini_idx.push_back(int'(line_idx_o));
        ini_r0.push_back(int'(r_0_o));
        ini_np.push_back(int'(num_points_o));
      end
      if (frame_done_o) fd_cyc.push_back(cyc);
    end
  end

  // Transmitter stand-in.
  initial begin
    tx_done_i = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_mode == 2) tx_done_i = 1'b1;
      else if (resp_mode == 1) tx_done_i = 1'b0;
      else begin
        tx_done_i = 1'b0;
        if (initiate_o) begin
          for (int i = 0; i < resp_lat; i++) @(negedge clk);
          tx_done_i = 1'b1;
          @(negedge clk);
          tx_done_i = 1'b0;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic clear_log();
    ini_cyc.delete(); ini_ang.delete(); ini_idx.delete();
    ini_r0.delete(); ini_np.delete(); fd_cyc.delete();
  endtask

  // Reference: list of angles a frame visits, in unbounded integer arithmetic.
  task automatic build_model(input int a0, input int a1, input int st);
    int a;
    exp_ang.delete();
    a = a0;
    exp_ang.push_back(a);
    if (st != 0) begin
      while (a + st <= a1) begin
        a = a + st;
        exp_ang.push_back(a);
      end
    end
  endtask

  task automatic run_frame(input int a0, input int a1, input int st, input int d,
                           input int lat, input int mode, input bit poke);
    int s, w, dd, per, b, n;
    clear_log();
    resp_mode = mode;
    resp_lat = lat;
    cur_r0 = $urandom_range(0, 255);
    cur_np = $urandom_range(0, 8191);
    angle_start_i = 8'(a0); angle_stop_i = 8'(a1); angle_step_i = 8'(st);
    r_0_cfg_i = 8'(cur_r0); num_points_cfg_i = 13'(cur_np); dwell_cycles_i = 16'(d);
    @(negedge clk);
    start_i = 1'b1;
    s = cyc;
    @(negedge clk);
    start_i = 1'b0;
    check("busy_in_load", busy_o, 1);
    check("error_in_load", error_o, 0);
    @(negedge clk);
    angle_start_i = 8'($urandom); angle_stop_i = 8'($urandom); angle_step_i = 8'($urandom);
    r_0_cfg_i = 8'($urandom); num_points_cfg_i = 13'($urandom); dwell_cycles_i = 16'($urandom);
    if (poke) start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    b = 0;
    while (!frame_done_o && b < 20000) begin
      @(negedge clk);
      b++;
    end
    @(negedge clk);
    check("busy_after_done", busy_o, 0);
    build_model(a0, a1, st);
    check("line_count", ini_cyc.size(), exp_ang.size());
    check("first_initiate_cycle", ini_cyc.size() > 0 ? ini_cyc[0] : -1, s + 2);
    w = (mode == 2) ? 1 : lat;
    dd = (d < 1) ? 1 : d;
    per = w + dd + 2;
    n = (ini_cyc.size() < exp_ang.size()) ? ini_cyc.size() : exp_ang.size();
    for (int i = 0; i < n; i++) begin
      check("line_angle", ini_ang[i], exp_ang[i]);
      check("line_idx", ini_idx[i], (i > 255) ? 255 : i);
      check("line_r0", ini_r0[i], cur_r0);
      check("line_np", ini_np[i], cur_np);
      if (i > 0) check("line_period", ini_cyc[i] - ini_cyc[i-1], per);
    end
    check("frame_done_count", fd_cyc.size(), 1);
    if (fd_cyc.size() > 0 && ini_cyc.size() > 0)
      check("frame_done_cycle", fd_cyc[0] - ini_cyc[ini_cyc.size()-1], w + dd + 2);
    check("error_clear", error_o, 0);
  endtask

  initial begin
    vec_t vecs[9];
    int b, s, last;
    vecs[0] = '{60, 64, 2, 3, 20, 0, 3, 64};
    vecs[1] = '{60, 64, 0, 3, 5, 0, 1, 60};
    vecs[2] = '{70, 60, 5, 2, 4, 0, 1, 70};
    vecs[3] = '{250, 255, 10, 1, 3, 0, 1, 250};
    vecs[4] = '{0, 255, 51, 0, 2, 0, 6, 255};
    vecs[5] = '{10, 20, 5, 0, 1, 2, 3, 20};
    vecs[6] = '{0, 255, 1, 0, 1, 0, 256, 255};
    vecs[7] = '{255, 255, 1, 2, 2, 0, 1, 255};
    vecs[8] = '{5, 6, 1, 1, 1, 2, 2, 6};

    rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0;
    angle_start_i = 8'd0; angle_stop_i = 8'd0; angle_step_i = 8'd0;
    r_0_cfg_i = 8'd0; num_points_cfg_i = 13'd0; dwell_cycles_i = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy_o, 0);
    check("rst_initiate", initiate_o, 0);
    check("rst_frame_done", frame_done_o, 0);
    check("rst_error", error_o, 0);
    check("rst_line_idx", line_idx_o, 0);
    check("rst_angle", angle_o, 0);
    check("rst_r0", r_0_o, 0);
    check("rst_np", num_points_o, 0);
    rst_ni = 1'b1;
    @(negedge clk);

    // start together with abort in IDLE must not leave IDLE
    start_i = 1'b1; abort_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; abort_i = 1'b0;
    check("start_abort_idle", busy_o, 0);
    @(negedge clk);
    check("start_abort_idle2", busy_o, 0);

    foreach (vecs[k]) begin
      run_frame(vecs[k].a0, vecs[k].a1, vecs[k].st, vecs[k].d, vecs[k].lat, vecs[k].mode, 1'b0);
      check("vec_lines", ini_cyc.size(), vecs[k].exp_lines);
      last = (ini_ang.size() > 0) ? ini_ang[ini_ang.size()-1] : -1;
      check("vec_last_angle", last, vecs[k].exp_last);
    end

    for (int r = 0; r < 12; r++) begin
      int a0, a1, st;
      a0 = $urandom_range(0, 255);
      a1 = $urandom_range(0, 255);
      st = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(1, 60);
      run_frame(a0, a1, st, $urandom_range(0, 4), $urandom_range(1, 6),
                ($urandom_range(0, 3) == 0) ? 2 : 0, 1'b1);
    end

    // Abort in the second DWELL cycle of line 1
    clear_log();
    resp_mode = 0; resp_lat = 20;
    angle_start_i = 8'd60; angle_stop_i = 8'd64; angle_step_i = 8'd2; dwell_cycles_i = 16'd3;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    b = 0;
    while (ini_cyc.size() < 2 && b < 500) begin @(negedge clk); b++; end
    check("abort_reached_line1", (ini_cyc.size() >= 2) ? 1 : 0, 1);
    if (ini_cyc.size() >= 2) begin
      s = ini_cyc[1] + 22;
      while (cyc < s && b < 1000) begin @(negedge clk); b++; end
    end
    check("busy_before_abort", busy_o, 1);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("abort_busy", busy_o, 0);
    check("abort_initiate", initiate_o, 0);
    check("abort_angle_hold", angle_o, 62);
    repeat (40) @(negedge clk);
    check("abort_initiates", ini_cyc.size(), 2);
    check("abort_no_frame_done", fd_cyc.size(), 0);
    check("abort_error", error_o, 0);

    // Watchdog: done never arrives
    clear_log();
    resp_mode = 1;
    angle_start_i = 8'd30; angle_stop_i = 8'd40; angle_step_i = 8'd5; dwell_cycles_i = 16'd1;
    @(negedge clk);
    start_i = 1'b1;
    s = cyc;
    @(negedge clk);
    start_i = 1'b0;
    b = 0;
    while (busy_o && b < 6000) begin @(negedge clk); b++; end
    check("watchdog_idle_cycle", cyc, s + 4098);
    check("watchdog_error", error_o, 1);
    check("watchdog_initiates", ini_cyc.size(), 1);
    check("watchdog_no_frame_done", fd_cyc.size(), 0);
    repeat (5) @(negedge clk);
    check("error_sticky", error_o, 1);
    run_frame(20, 30, 5, 2, 3, 0, 1'b0);

    // Async reset in the middle of WAIT_TX
    clear_log();
    resp_mode = 1;
    angle_start_i = 8'd60; angle_stop_i = 8'd64; angle_step_i = 8'd2;
    r_0_cfg_i = 8'd9; num_points_cfg_i = 13'd77;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (10) @(negedge clk);
    check("busy_before_reset", busy_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_busy", busy_o, 0);
    check("arst_initiate", initiate_o, 0);
    check("arst_frame_done", frame_done_o, 0);
    check("arst_error", error_o, 0);
    check("arst_line_idx", line_idx_o, 0);
    check("arst_angle", angle_o, 0);
    check("arst_r0", r_0_o, 0);
    check("arst_np", num_points_o, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    run_frame(100, 110, 4, 1, 2, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
